cmd_bus_arbiter: RTL and testbench

Shares the external chip command bus between NUM_REQ requesters: the time-stamped command scheduler, the DAC sample feeder and the host readback path.
- Arbitrates round-robin and runs one fixed-timing bus cycle per grant (setup, strobe, hold).
- Returns read data and a completion pulse to the granted requester.
- Is the only driver of cmd_bus_*.

---
 rtl/cmd_bus_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_cmd_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_bus_arbiter.sv
// Round-robin owner of the external command bus: one setup/strobe/hold cycle per grant, done pulse on return to IDLE.
// Optional CMD_BUS_WAIT_EN adds cmd_bus_wait strobe extension (255-cycle limit) and a timeout pulse.
module cmd_bus_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         cmd_bus_addr,
  output logic [DATA_W-1:0]         cmd_bus_data,
  input  logic [DATA_W-1:0]         cmd_bus_din,
  output logic                      cmd_bus_en,
  output logic                      cmd_bus_rd,
  output logic                      cmd_bus_wr
`ifdef CMD_BUS_WAIT_EN
  ,
  input  logic                      cmd_bus_wait,
  output logic                      timeout
`endif
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               en_q, en_d;
  logic               rd_q, rd_d;
  logic               wrs_q, wrs_d;
`ifdef CMD_BUS_WAIT_EN
  logic [7:0]         ext_q, ext_d;
  logic               to_q, to_d;
  logic               timeout_q, timeout_d;
`endif

  logic [NUM_REQ-1:0] eligible;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               strobe_end;

  // A requester whose done pulse is showing this cycle is masked, so it cannot re-win immediately.
  always_comb begin
    eligible  = req & ~done_q;
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    done_d     = '0;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    data_d     = data_q;
    en_d       = en_q;
    rd_d       = rd_q;
    wrs_d      = wrs_q;
    strobe_end = 1'b0;
`ifdef CMD_BUS_WAIT_EN
    ext_d      = ext_q;
    to_d       = to_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d = S_SETUP;
          busy_d  = 1'b1;
          ptr_d   = gnt_idx;
          gnt_d   = gnt_idx;
          wr_d    = req_wr[gnt_idx];
          addr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          data_d  = req_wr[gnt_idx] ? req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
          en_d    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_W'(STROBE_CYC - 1);
        rd_d    = !wr_q;
        wrs_d   = wr_q;
`ifdef CMD_BUS_WAIT_EN
        ext_d   = '0;
        to_d    = 1'b0;
`endif
      end
      S_STROBE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
`ifdef CMD_BUS_WAIT_EN
        else if (cmd_bus_wait && ext_q != 8'hFF) ext_d = ext_q + 8'd1;
`endif
        else strobe_end = 1'b1;
        if (strobe_end) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          rd_d    = 1'b0;
          wrs_d   = 1'b0;
          if (!wr_q) rd_data_d = cmd_bus_din;
`ifdef CMD_BUS_WAIT_EN
          // Still waiting after the last allowed extension: give up, report zero data.
          to_d = cmd_bus_wait;
          if (!wr_q && cmd_bus_wait) rd_data_d = '0;
`endif
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d        = S_IDLE;
          busy_d         = 1'b0;
          en_d           = 1'b0;
          done_d[gnt_q]  = 1'b1;
`ifdef CMD_BUS_WAIT_EN
          timeout_d      = to_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      done_q    <= '0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      rd_q      <= 1'b0;
      wrs_q     <= 1'b0;
`ifdef CMD_BUS_WAIT_EN
      ext_q     <= '0;
      to_q      <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      en_q      <= en_d;
      rd_q      <= rd_d;
      wrs_q     <= wrs_d;
`ifdef CMD_BUS_WAIT_EN
      ext_q     <= ext_d;
      to_q      <= to_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign done         = done_q;
  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign cmd_bus_addr = addr_q;
  assign cmd_bus_data = data_q;
  assign cmd_bus_en   = en_q;
  assign cmd_bus_rd   = rd_q;
  assign cmd_bus_wr   = wrs_q;
`ifdef CMD_BUS_WAIT_EN
  assign timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Bench for cmd_bus_arbiter: directed scenarios plus randomized requesters against a
// transaction-level model (grant by round-robin rule, bus signals from phase offset since grant).
module tb_cmd_bus_arbiter;
  localparam int N = 3, AW = 19, DW = 16, S = 2, H = 1;
  localparam int L = 2 + S + H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] cmd_bus_din = '0;
  logic [N-1:0]  done;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] cmd_bus_addr;
  logic [DW-1:0] cmd_bus_data;
  logic          cmd_bus_en, cmd_bus_rd, cmd_bus_wr;
`ifdef CMD_BUS_WAIT_EN
  logic          cmd_bus_wait = 1'b0;
  logic          timeout;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cmd_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STROBE_CYC(S), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .rd_data(rd_data), .busy(busy),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data), .cmd_bus_din(cmd_bus_din),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_rd(cmd_bus_rd), .cmd_bus_wr(cmd_bus_wr)
`ifdef CMD_BUS_WAIT_EN
    , .cmd_bus_wait(cmd_bus_wait), .timeout(timeout)
`endif
  );

  // Transaction-level reference: active transaction, cycles since grant, latched request.
  bit            m_act;
  int            m_k, m_gnt, m_ptr;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd;
  logic [N-1:0]  m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    bit found;
    int idx;
    if (rst) begin
      m_act = 0; m_k = 0; m_ptr = N - 1; m_done = '0; m_rd = '0; m_addr = '0; m_data = '0;
    end else if (!m_act) begin
      elig = req & ~m_done;
      m_done = '0;
      found = 0;
      for (int j = 1; j <= N; j++) begin
        idx = (m_ptr + j) % N;
        if (!found && elig[idx]) begin found = 1; m_gnt = idx; end
      end
      if (found) begin
        m_ptr  = m_gnt;
        m_act  = 1;
        m_k    = 1;
        m_wr   = req_wr[m_gnt];
        m_addr = req_addr[m_gnt*AW +: AW];
        m_data = m_wr ? req_wdata[m_gnt*DW +: DW] : '0;
      end
    end else begin
      m_done = '0;
      if (m_k == 1 + S && !m_wr) m_rd = cmd_bus_din;
      m_k++;
      if (m_k == L) begin m_act = 0; m_done[m_gnt] = 1'b1; end
    end
  endtask

  task automatic cycle();
    bit in_strobe;
    @(posedge clk);
    model_step();
    @(negedge clk);
    in_strobe = m_act && m_k >= 2 && m_k <= 1 + S;
    chk("done",    32'(done),         32'(m_done));
    chk("busy",    32'(busy),         32'(m_act));
    chk("en",      32'(cmd_bus_en),   32'(m_act));
    chk("wr",      32'(cmd_bus_wr),   32'(in_strobe && m_wr));
    chk("rd",      32'(cmd_bus_rd),   32'(in_strobe && !m_wr));
    chk("addr",    32'(cmd_bus_addr), 32'(m_addr));
    chk("data",    32'(cmd_bus_data), 32'(m_data));
    chk("rd_data", 32'(rd_data),      32'(m_rd));
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [4:0] en_h, wr_h, rd_h, dn_h;
    int order[6];
    int dcyc[6];
    int ndone, cyc, waited;
    logic [N-1:0] first;

    // Reset
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(cmd_bus_en), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // Single write from requester 0
    set_req(0, 1'b1, 19'h01234, 16'hBEEF);
    en_h = '0; wr_h = '0; rd_h = '0; dn_h = '0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      en_h[c] = cmd_bus_en; wr_h[c] = cmd_bus_wr; rd_h[c] = cmd_bus_rd; dn_h[c] = done[0];
      if (c == 0) begin
        chk("wr_addr", 32'(cmd_bus_addr), 32'h01234);
        chk("wr_data", 32'(cmd_bus_data), 32'hBEEF);
      end
    end
    req[0] = 1'b0;
    chk("wr_en_seq", 32'(en_h), 32'b01111);
    chk("wr_wr_seq", 32'(wr_h), 32'b00110);
    chk("wr_rd_seq", 32'(rd_h), 32'b00000);
    chk("wr_done_seq", 32'(dn_h), 32'b10000);
    cycle();

    // Single read from requester 2
    set_req(2, 1'b0, 19'h70001, 16'h1111);
    cmd_bus_din = 16'h5A5A;
    en_h = '0; wr_h = '0; rd_h = '0; dn_h = '0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      wr_h[c] = cmd_bus_wr; rd_h[c] = cmd_bus_rd; dn_h[c] = done[2];
      if (c == 0) chk("rd_setup_data", 32'(cmd_bus_data), 32'd0);
    end
    chk("rd_rd_data", 32'(rd_data), 32'h5A5A);
    req[2] = 1'b0;
    chk("rd_rd_seq", 32'(rd_h), 32'b00110);
    chk("rd_wr_seq", 32'(wr_h), 32'b00000);
    chk("rd_done_seq", 32'(dn_h), 32'b10000);
    cmd_bus_din = 16'h0F0F;
    cycle();

    // All three held: strict round-robin, 5-cycle spacing
    set_req(0, 1'b1, 19'h00010, 16'hA000);
    set_req(1, 1'b0, 19'h00020, 16'hB000);
    set_req(2, 1'b1, 19'h00030, 16'hC000);
    ndone = 0; cyc = 0;
    for (int i = 0; i < 6; i++) begin order[i] = -1; dcyc[i] = -1; end
    while (ndone < 6 && cyc < 40) begin
      cycle();
      cyc++;
      for (int j = 0; j < N; j++)
        if (done[j] && ndone < 6) begin order[ndone] = j; dcyc[ndone] = cyc; ndone++; end
      if (ndone == 6) req = '0;
    end
    req = '0;
    chk("rr_count", 32'(ndone), 32'd6);
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(order[i]), 32'(i % 3));
    for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(dcyc[i] - dcyc[i-1]), 32'(L));
    for (int i = 0; i < 8; i++) cycle();

    // Reset during the strobe of a write; pointer returns so requester 0 wins next
    set_req(0, 1'b1, 19'h00555, 16'h1234);
    cycle(); cycle();
    chk("pre_rst_wr", 32'(cmd_bus_wr), 32'd1);
    rst = 1'b1;
    set_req(1, 1'b1, 19'h00666, 16'h5678);
    set_req(2, 1'b0, 19'h00777, 16'h0000);
    cycle();
    chk("mid_rst_en", 32'(cmd_bus_en), 32'd0);
    chk("mid_rst_wr", 32'(cmd_bus_wr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    first = '0; waited = 0;
    while (first == '0 && waited < 20) begin cycle(); waited++; first = done; end
    chk("post_rst_grant", 32'(first), 32'b001);
    req = '0;
    for (int i = 0; i < 15; i++) cycle();

    // Requester 1 keeps req high through its done cycle: masked once, then regranted
    set_req(1, 1'b1, 19'h01111, 16'h2222);
    waited = 0;
    while (!done[1] && waited < 20) begin cycle(); waited++; end
    chk("mask_done_seen", 32'(done[1]), 32'd1);
    cycle();
    chk("mask_en", 32'(cmd_bus_en), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    cycle();
    chk("regrant_en", 32'(cmd_bus_en), 32'd1);
    req = '0;
    for (int i = 0; i < 8; i++) cycle();

    // Randomized requesters with occasional resets
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      cmd_bus_din = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (m_done[i]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end else if (m_act && m_gnt == i && $urandom_range(0, 7) == 0) begin
          // dropped and scrambled after grant: the running cycle must be unaffected
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
          req[i] = 1'b0;
        end
      end
      cycle();
    end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 10; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
